// File: rtl/ramblock_sync.sv
// ramblock_sync: single-port RAM with byte enables, registered read and a clear sweep.
module ramblock_sync #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 15,
  parameter logic [DATA_W-1:0] INIT_VAL = '0,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req,
  input  logic                wr,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   din,
  input  logic [DATA_W/8-1:0] ben,
  input  logic                clear,
  output logic                ready,
  output logic [DATA_W-1:0]   dout,
  output logic                dout_valid,
  output logic                busy
);
  localparam int NB = DATA_W / 8;
  typedef enum logic {CLEAR, IDLE} state_t;
  state_t state, state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] merged;
  logic accept;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= CLEAR_ON_RESET ? CLEAR : IDLE;
      ptr <= '0;
    end else begin
      state <= state_nxt;
      ptr <= state == CLEAR ? ptr + 1'b1 : '0;
    end
  always_comb state_nxt = state == CLEAR ? (&ptr ? IDLE : CLEAR) : (clear ? CLEAR : IDLE);
  always_comb begin
    busy = state == CLEAR;
    ready = state == IDLE && !clear;
    accept = req && ready;
  end
  // Read and write share one path: the merged word is both what gets stored and what is returned.
  always_comb begin
    merged = mem[address];
    for (int i = 0; i < NB; i++)
      merged[8*i +: 8] = (wr && ben[i]) ? din[8*i +: 8] : mem[address][8*i +: 8];
  end
  always_ff @(posedge clk)
    if (busy) mem[ptr] <= INIT_VAL;
    else if (accept && wr) mem[address] <= merged;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      dout <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= accept;
      if (accept) dout <= merged;
    end
endmodule

// File: tb/tb_ramblock_sync.sv
// tb_ramblock_sync: randomized and directed checks of ramblock_sync against a word-level model.
module tb_ramblock_sync;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam int DEPTH = 16;
  localparam logic [DW-1:0] INIT = 16'hA5A5;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req = 1'b0, wr = 1'b0, clear = 1'b0;
  logic [AW-1:0] address = '0;
  logic [DW-1:0] din = '0;
  logic [DW/8-1:0] ben = '0;
  logic ready, dout_valid, busy;
  logic [DW-1:0] dout;
  int vectors = 0, miscompares = 0;
  logic [DW-1:0] m_mem [DEPTH];
  logic [DW-1:0] m_dout = '0;
  logic m_valid = 1'b0;
  int m_left = 0;
  ramblock_sync #(.DATA_W(DW), .ADDR_W(AW), .INIT_VAL(INIT), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .address(address), .din(din), .ben(ben),
    .clear(clear), .ready(ready), .dout(dout), .dout_valid(dout_valid), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic tick();
    logic [DW-1:0] w;
    #1;
    chk("busy", busy, m_left > 0);
    chk("ready", ready, m_left == 0 && !clear);
    if (m_left > 0) begin
      m_mem[DEPTH - m_left] = INIT;
      m_left--;
      m_valid = 1'b0;
    end else if (clear) begin
      m_left = DEPTH;
      m_valid = 1'b0;
    end else if (req) begin
      w = m_mem[address];
      if (wr)
        for (int i = 0; i < DW / 8; i++)
          if (ben[i]) w[8*i +: 8] = din[8*i +: 8];
      m_mem[address] = w;
      m_dout = w;
      m_valid = 1'b1;
    end else m_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("dout", dout, m_dout);
    chk("dout_valid", dout_valid, m_valid);
  endtask
  task automatic access(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] b);
    req = 1'b1;
    wr = w;
    address = a;
    din = d;
    ben = b;
    tick();
    req = 1'b0;
  endtask
  task automatic sweep_check(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      chk({tag, "_busy"}, busy, 1'b1);
      chk({tag, "_notready"}, ready, 1'b0);
      tick();
    end
    #1;
    chk({tag, "_ready_back"}, ready, 1'b1);
    chk({tag, "_busy_low"}, busy, 1'b0);
  endtask
  task automatic read_all(input string tag);
    for (int a = 0; a < DEPTH; a++) begin
      access(1'b0, AW'(a), '0, '0);
      chk(tag, dout, INIT);
      chk({tag, "_v"}, dout_valid, 1'b1);
    end
  endtask
  initial begin
    #2 rst = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_dout", dout, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_busy", busy, 1);
    chk("rst_ready", ready, 0);
    rst = 1'b1;
    m_left = DEPTH;
    sweep_check("init");
    access(1'b0, 4'd0, '0, '0);
    chk("t1_rd0", dout, 16'hA5A5);
    access(1'b0, 4'd15, '0, '0);
    chk("t1_rd15", dout, 16'hA5A5);
    chk("t1_valid", dout_valid, 1);
    access(1'b1, 4'd3, 16'h1234, 2'b11);
    chk("t2_wdout", dout, 16'h1234);
    chk("t2_wvalid", dout_valid, 1);
    access(1'b0, 4'd3, '0, '0);
    chk("t2_rd3", dout, 16'h1234);
    access(1'b0, 4'd2, '0, '0);
    chk("t2_rd2", dout, 16'hA5A5);
    access(1'b1, 4'd3, 16'hBEEF, 2'b01);
    chk("t3_merge", dout, 16'h12EF);
    access(1'b0, 4'd3, '0, '0);
    chk("t3_rd3", dout, 16'h12EF);
    for (int i = 0; i < 3; i++) begin
      din = 16'($urandom);
      address = 4'($urandom);
      tick();
      chk("t4_hold", dout, 16'h12EF);
      chk("t4_novalid", dout_valid, 0);
    end
    access(1'b1, 4'd7, 16'h0F0F, 2'b11);
    din = 16'hFFFF;
    #2;
    chk("t4_din_after_edge", dout, 16'h0F0F);
    access(1'b1, 4'd7, 16'hFFFF, 2'b00);
    chk("t4_ben0", dout, 16'h0F0F);
    clear = 1'b1;
    req = 1'b1;
    wr = 1'b1;
    address = '0;
    din = 16'h5555;
    ben = 2'b11;
    #1;
    chk("t5_ready", ready, 0);
    tick();
    clear = 1'b0;
    req = 1'b0;
    sweep_check("t5");
    read_all("t5_rd");
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    #3 rst = 1'b0;
    #1;
    chk("t6_dout", dout, 0);
    chk("t6_valid", dout_valid, 0);
    m_dout = '0;
    m_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    m_left = DEPTH;
    sweep_check("t6");
    read_all("t6_rd");
    for (int n = 0; n < 400; n++) begin
      clear = $urandom_range(0, 59) == 0;
      req = 1'($urandom);
      wr = 1'($urandom);
      address = 4'($urandom);
      din = 16'($urandom);
      ben = 2'($urandom);
      tick();
    end
    clear = 1'b0;
    req = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) tick();
    for (int a = 0; a < DEPTH; a++) begin
      access(1'b0, AW'(a), '0, '0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
